spi_sram_ctrl: RTL and testbench

// Responder side of the CPU memory handshake. Accepts one byte-access request (mem_req/mem_ready)

---
 rtl/spi_sram_pkg.sv | 28 ++
 rtl/spi_sclk_div.sv | 47 ++++
 rtl/spi_sram_ctrl.sv | 144 ++++++++++++++
 tb/tb_spi_sram_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sram_pkg.sv
// Shared types and constants for the SPI SRAM controller.
//   state_e       : controller FSM states
//   SPI_CMD_*     : 23LC512 instruction bytes
//   XFER_BITS     : bits per CS-framed transaction (cmd + addr + data)
//   spi_frame()   : builds the 32-bit outbound frame for one access
package spi_sram_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone,
        StGap
    } state_e;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam int unsigned XFER_BITS    = 32;

    // Reads clock out zeros during the data byte; the SRAM ignores MOSI there.
    function automatic logic [31:0] spi_frame(input logic       is_write,
                                              input logic [15:0] addr,
                                              input logic [7:0]  wdata);
        logic [7:0] cmd;
        cmd = is_write ? SPI_CMD_WRITE : SPI_CMD_READ;
        return {cmd, addr, (is_write ? wdata : 8'h00)};
    endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// SPI clock generator for mode 0.
//   clk, rst_n : system clock, async active-low reset
//   en         : run the divider; when low sclk is held low and the phase counter cleared
//   sclk       : registered SPI clock, CLK_DIV clk cycles per half-period
//   rise_tick  : high in the clk cycle whose closing edge drives sclk 0->1
//   fall_tick  : high in the clk cycle whose closing edge drives sclk 1->0
module spi_sclk_div #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic            sclk_q;
    logic            half_done;

    always_comb begin
        half_done = en && (cnt_q == CntMax);
        rise_tick = half_done && !sclk_q;
        fall_tick = half_done && sclk_q;
        sclk      = sclk_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (!en) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (half_done) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_sram_ctrl.sv
// Byte-access bridge from the CPU memory handshake to a 64KB SPI SRAM (23LC512, mode 0).
// Each accepted request becomes one CS-framed transaction: cmd(8) addr(16) data(8), MSB first.
//   clk, rst_n          : system clock, async active-low reset
//   mem_req             : request, sampled only while idle
//   mem_read, mem_write : operation qualifiers; write wins, neither means read
//   mem_addr, mem_wdata : latched when the request is accepted
//   mem_rdata           : last read byte, updated together with the mem_ready pulse
//   mem_ready           : one-cycle completion pulse
//   spi_cs_n, spi_sclk, spi_mosi, spi_miso : SRAM pins
module spi_sram_ctrl
    import spi_sram_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        mem_ready,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GapW-1:0] GapMax = GapW'(CS_GAP - 1);
    localparam logic [4:0] LastBit = 5'(XFER_BITS - 1);

    state_e          state_q;
    logic [31:0]     tx_q;
    logic [7:0]      rx_q;
    logic [4:0]      bit_cnt_q;
    logic            op_write_q;
    logic [GapW-1:0] gap_cnt_q;
    logic            cs_n_q;
    logic            mosi_q;
    logic            ready_q;
    logic [7:0]      rdata_q;

    logic            req_write;
    logic [31:0]     tx_load;
    logic            sclk_en;
    logic            rise_tick;
    logic            fall_tick;

    // Write has priority; a request with neither qualifier is a read.
    always_comb begin
        req_write = 1'b0;
        case ({mem_write, mem_read})
            2'b10, 2'b11: req_write = 1'b1;
            default:      req_write = 1'b0;
        endcase
        tx_load = spi_frame(req_write, mem_addr, mem_wdata);
        sclk_en = (state_q == StShift);
    end

    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (sclk_en),
        .sclk      (spi_sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_cnt_q  <= '0;
            op_write_q <= 1'b0;
            gap_cnt_q  <= '0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_req) begin
                        tx_q       <= tx_load;
                        op_write_q <= req_write;
                        bit_cnt_q  <= '0;
                        cs_n_q     <= 1'b0;
                        mosi_q     <= tx_load[31];
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    // MISO is stable here: the SRAM changed it on the previous sclk fall.
                    if (rise_tick) begin
                        rx_q <= {rx_q[6:0], spi_miso};
                    end
                    if (fall_tick) begin
                        if (bit_cnt_q == LastBit) begin
                            mosi_q  <= 1'b0;
                            ready_q <= 1'b1;
                            if (!op_write_q) begin
                                rdata_q <= rx_q;
                            end
                            state_q <= StDone;
                        end else begin
                            tx_q      <= {tx_q[30:0], 1'b0};
                            mosi_q    <= tx_q[30];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    ready_q   <= 1'b0;
                    cs_n_q    <= 1'b1;
                    gap_cnt_q <= '0;
                    state_q   <= StGap;
                end
                StGap: begin
                    // cs_n stays high through GAP plus the IDLE sampling cycle.
                    if (gap_cnt_q == GapMax) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        spi_cs_n  = cs_n_q;
        spi_mosi  = mosi_q;
        mem_ready = ready_q;
        mem_rdata = rdata_q;
    end

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Bench for spi_sram_ctrl: two instances (CLK_DIV=1 and CLK_DIV=3) share one 23LC512 model
// through a pin mux; only the selected instance is ever given requests.
module tb_spi_sram_ctrl;

    localparam int DIV0 = 1;
    localparam int DIV1 = 3;
    localparam int GAP  = 2;

    typedef struct {
        int         g;
        logic       rd;
        logic       wr;
        logic [15:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic [31:0] exp_frame;
        logic [7:0] exp_mem;
    } vec_t;

    typedef struct {
        int         g;
        logic [7:0] rdata;
        int         lat;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mem_req = '0;
    logic [1:0]  mem_read = '0;
    logic [1:0]  mem_write = '0;
    logic [15:0] mem_addr [2];
    logic [7:0]  mem_wdata [2];
    logic [7:0]  mem_rdata [2];
    logic [1:0]  mem_ready;
    logic [1:0]  cs_n;
    logic [1:0]  sclk;
    logic [1:0]  mosi;
    logic        sel = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic m_miso = 1'b0;

    spi_sram_ctrl #(.CLK_DIV(DIV0), .CS_GAP(GAP)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req[0]), .mem_read(mem_read[0]),
        .mem_write(mem_write[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]), .spi_cs_n(cs_n[0]),
        .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_miso(m_miso)
    );

    spi_sram_ctrl #(.CLK_DIV(DIV1), .CS_GAP(GAP)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req[1]), .mem_read(mem_read[1]),
        .mem_write(mem_write[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]), .spi_cs_n(cs_n[1]),
        .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_miso(m_miso)
    );

    // ---------------- 23LC512 model (mode 0, byte mode) ----------------
    logic        m_cs_n, m_sclk, m_mosi;
    logic [7:0]  sram [65536];
    logic [5:0]  m_rises = '0;
    logic [31:0] m_shift = '0;
    logic [7:0]  m_cmd = '0;
    logic [7:0]  m_rd = '0;
    logic [31:0] last_frame = '0;
    logic [5:0]  last_rises = '0;

    assign m_cs_n = cs_n[sel];
    assign m_sclk = sclk[sel];
    assign m_mosi = mosi[sel];

    always @(posedge m_sclk or negedge m_cs_n) begin
        if (!m_sclk) begin
            m_rises <= '0;
            m_shift <= '0;
        end else if (!m_cs_n) begin
            m_shift <= {m_shift[30:0], m_mosi};
            m_rises <= m_rises + 6'd1;
            if (m_rises == 6'd7) m_cmd <= {m_shift[6:0], m_mosi};
            if (m_rises == 6'd23) m_rd <= sram[{m_shift[14:0], m_mosi}];
            if (m_rises == 6'd31) begin
                last_frame <= {m_shift[30:0], m_mosi};
                if (m_cmd == 8'h02) sram[m_shift[22:7]] <= {m_shift[6:0], m_mosi};
            end
        end
    end

    always @(negedge m_sclk) begin
        if (!m_cs_n && m_cmd == 8'h03 && m_rises >= 6'd24 && m_rises < 6'd32)
            m_miso <= m_rd[3'(6'd31 - m_rises)];
        else
            m_miso <= 1'b0;
    end

    always @(posedge m_cs_n) last_rises <= m_rises;

    // ---------------- monitor: records ready events and pin invariants ----------------
    xfer_t ev_q[$];
    int    acc_cyc [2] = '{0, 0};
    int    hi_cnt [2] = '{0, 0};
    int    last_gap [2] = '{0, 0};
    logic [1:0] cs_prev = 2'b11;
    int    viol = 0;

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst_n) begin
                if (!cs_n[g] && cs_prev[g]) begin
                    acc_cyc[g]  <= cyc;
                    last_gap[g] <= hi_cnt[g];
                end
                hi_cnt[g] <= cs_n[g] ? hi_cnt[g] + 1 : 0;
                if (mem_ready[g]) ev_q.push_back('{g, mem_rdata[g], cyc - acc_cyc[g]});
            end
            if (cs_n[g] && (sclk[g] || mosi[g])) viol <= viol + 1;
            cs_prev[g] <= cs_n[g];
        end
    end

    // ---------------- checking helpers ----------------
    xfer_t sb_q[$];
    vec_t  vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic process_events();
        xfer_t ev, ex;
        while (ev_q.size() > 0) begin
            ev = ev_q.pop_front();
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_ready actual=dut%0d ready expected=no pulse", ev.g);
            end else begin
                ex = sb_q.pop_front();
                chk("ready_dut", ev.g, ex.g);
                chk("rdata_at_ready", {24'h0, ev.rdata}, {24'h0, ex.rdata});
                chk("ready_latency", ev.lat, ex.lat);
            end
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() > 0; i++) begin
            step();
            process_events();
        end
        if (sb_q.size() > 0) begin
            chk("ready_timeout_pending", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic drive(input vec_t v, input logic req);
        sel            = v.g[0];
        mem_read[v.g]  = v.rd;
        mem_write[v.g] = v.wr;
        mem_addr[v.g]  = v.addr;
        mem_wdata[v.g] = v.wdata;
        mem_req[v.g]   = req;
    endtask

    task automatic wait_accept(input int g);
        int i;
        for (i = 0; i < 20 && cs_n[g]; i++) step();
        chk("accept_cs_low", cs_n[g], 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        int div;
        div = (v.g == 1) ? DIV1 : DIV0;
        step();
        drive(v, 1'b1);
        // Ready is the (64*CLK_DIV+1)th cycle counting the accept cycle as the first.
        sb_q.push_back('{v.g, v.exp_rdata, 64 * div});
        wait_accept(v.g);
        mem_req[v.g] = 1'b0;
        drain(300 * div);
        for (int i = 0; i < 12; i++) step();
        process_events();
        chk("no_extra_ready", ev_q.size(), 0);
        chk("mosi_frame", last_frame, v.exp_frame);
        chk("sclk_rises", {26'h0, last_rises}, 32);
        chk("sram_content", {24'h0, sram[v.addr]}, {24'h0, v.exp_mem});
        chk("rdata_held", {24'h0, mem_rdata[v.g]}, {24'h0, v.exp_rdata});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        mem_addr  = '{16'h0, 16'h0};
        mem_wdata = '{8'h0, 8'h0};

        //        g  rd  wr  addr      wdata  rdata  frame          mem
        vecs[0] = '{0, 0, 1, 16'h1234, 8'hA5, 8'h00, 32'h021234A5, 8'hA5};
        vecs[1] = '{0, 0, 1, 16'hBEEF, 8'h3C, 8'h00, 32'h02BEEF3C, 8'h3C};
        vecs[2] = '{0, 1, 0, 16'hBEEF, 8'h00, 8'h3C, 32'h03BEEF00, 8'h3C};
        vecs[3] = '{0, 1, 1, 16'h0000, 8'h77, 8'h3C, 32'h02000077, 8'h77};
        vecs[4] = '{0, 0, 0, 16'h1234, 8'h99, 8'hA5, 32'h03123400, 8'hA5};
        vecs[5] = '{0, 0, 1, 16'hFFFF, 8'hFF, 8'hA5, 32'h02FFFFFF, 8'hFF};
        vecs[6] = '{0, 1, 0, 16'hFFFF, 8'h00, 8'hFF, 32'h03FFFF00, 8'hFF};
        vecs[7] = '{1, 1, 0, 16'hBEEF, 8'h00, 8'h3C, 32'h03BEEF00, 8'h3C};

        // Reset state
        for (int i = 0; i < 3; i++) step();
        for (int g = 0; g < 2; g++) begin
            chk("rst_cs_n", cs_n[g], 1'b1);
            chk("rst_sclk", sclk[g], 1'b0);
            chk("rst_mosi", mosi[g], 1'b0);
            chk("rst_ready", mem_ready[g], 1'b0);
            chk("rst_rdata", {24'h0, mem_rdata[g]}, 32'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-to-back reads on the CLK_DIV=3 instance with mem_req held high
        step();
        drive(vecs[7], 1'b1);
        sb_q.push_back('{1, 8'h3C, 64 * DIV1});
        sb_q.push_back('{1, 8'h3C, 64 * DIV1});
        for (int i = 0; i < 1000 && sb_q.size() > 0; i++) begin
            step();
            process_events();
            if (sb_q.size() == 0) mem_req[1] = 1'b0;
        end
        mem_req[1] = 1'b0;
        chk("b2b_all_ready", sb_q.size(), 0);
        sb_q.delete();
        chk("b2b_cs_gap", last_gap[1], GAP + 1);
        for (int i = 0; i < 40; i++) step();
        process_events();
        chk("b2b_no_third_frame", ev_q.size(), 0);

        // Reset during bit 20 of a write to 16'h1234 (holds A5)
        v = '{0, 0, 1, 16'h1234, 8'hEE, 8'h00, 32'h0, 8'hA5};
        step();
        drive(v, 1'b1);
        wait_accept(0);
        mem_req[0] = 1'b0;
        for (int i = 0; i < 100 && m_rises < 6'd20; i++) step();
        chk("abort_reached_bit20", {26'h0, m_rises}, 20);
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", cs_n[0], 1'b1);
        chk("abort_sclk", sclk[0], 1'b0);
        chk("abort_ready", mem_ready[0], 1'b0);
        chk("abort_mosi", mosi[0], 1'b0);
        chk("abort_sram_kept", {24'h0, sram[16'h1234]}, 32'hA5);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("abort_rdata_reset", {24'h0, mem_rdata[0]}, 32'h0);
        run_vec('{0, 1, 0, 16'h1234, 8'h00, 8'hA5, 32'h03123400, 8'hA5});

        chk("pins_quiet_when_deselected", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
